// File: rtl/pwm_audio_out_if.sv
// rtl/pwm_audio_out_if.sv - sample stream handshake between mixer and PWM output stage
// Upstream (master) presents samples; the PWM stage (slave) reports buffer space.
interface pwm_audio_out_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/pwm_audio_out.sv
// rtl/pwm_audio_out.sv - double-buffered PWM audio renderer with underrun tracking
// Optional PWM_UNDERRUN_MUTE_EN: silence the output while starved instead of holding the last sample.
module pwm_audio_out #(
  parameter int WIDTH    = 12,
  parameter int PRESCALE = 1,
  parameter int UCNT_W   = 8
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              en,
  pwm_audio_out_if.slave    s_if,
  output logic              pwm_out,
  output logic              frame_start,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt,
  input  logic              clr_underrun
);
  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, STARVE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PSC_W-1:0]   r_psc;
  logic [WIDTH-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_duty;
  logic [WIDTH-1:0]   r_pend;
  logic               r_pend_full;
  logic               r_pwm;
  logic               r_fs;
  logic [UCNT_W-1:0]  r_ucnt;
  logic               w_tick;
  logic               w_boundary;
  logic               w_xfer;
  logic               w_load;
  logic               w_starve;

  assign w_tick     = en && (r_psc == PSC_MAX);
  assign w_boundary = w_tick && (r_cnt == CNT_MAX) && (r_state != IDLE);
  // Ready is a pure function of registered state, so a boundary that drains
  // the buffer cannot also accept in that cycle.
  assign w_xfer     = s_if.sample_valid && !r_pend_full;

  assign s_if.sample_ready = !r_pend_full;
  assign pwm_out           = r_pwm;
  assign frame_start       = r_fs;
  assign underrun          = (r_state == STARVE);
  assign underrun_cnt      = r_ucnt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_starve = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend_full) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN, STARVE: begin
        if (w_boundary) begin
          if (r_pend_full) begin
            w_next = RUN;
            w_load = 1'b1;
          end else begin
            w_next   = STARVE;
            w_starve = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_psc       <= '0;
      r_cnt       <= '0;
      r_duty      <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_pwm       <= 1'b0;
      r_fs        <= 1'b0;
      r_ucnt      <= '0;
    end else begin
      r_fs <= w_load || w_starve;

      if (w_load) begin
        r_pend_full <= 1'b0;
      end else if (w_xfer) begin
        r_pend      <= s_if.sample_in;
        r_pend_full <= 1'b1;
      end

      if (w_load) begin
        r_duty <= r_pend;
`ifdef PWM_UNDERRUN_MUTE_EN
      end else if (w_starve) begin
        r_duty <= '0;
`endif
      end

      // Prescaler is parked at 0 in IDLE so the first frame has full length.
      if (r_state == IDLE) begin
        r_psc <= '0;
      end else if (en) begin
        r_psc <= w_tick ? '0 : r_psc + PSC_W'(1);
      end

      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= r_cnt + WIDTH'(1);
      end

      if (!en || r_state == IDLE) begin
        r_pwm <= 1'b0;
      end else if (w_tick) begin
        r_pwm <= (r_cnt < r_duty);
      end

      if (clr_underrun) begin
        r_ucnt <= '0;
      end else if (w_starve && r_ucnt != '1) begin
        r_ucnt <= r_ucnt + UCNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pwm_audio_out.sv
// tb/tb_pwm_audio_out.sv - self-checking bench for pwm_audio_out
module tb_pwm_audio_out;
  localparam int W    = 4;
  localparam int PS   = 3;
  localparam int UW   = 2;
  localparam int FLEN = (1 << W) * PS;
`ifdef PWM_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nRst;
  logic          en;
  logic          clr_underrun;
  logic          pwm_out;
  logic          frame_start;
  logic          underrun;
  logic [UW-1:0] underrun_cnt;

  pwm_audio_out_if #(.WIDTH(W)) hs();

  pwm_audio_out #(.WIDTH(W), .PRESCALE(PS), .UCNT_W(UW)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .en           (en),
    .s_if         (hs),
    .pwm_out      (pwm_out),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .clr_underrun (clr_underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int highs;
    int len;
    bit urun;
    int rdy;
  } frame_t;

  int     sq[$];
  frame_t fq[$];
  frame_t cur;
  bit     open_f;
  int     fs_count;
  int     rd;
  bit     will_xfer;
  int     vectors = 0;
  int     miscompares = 0;

  // Upstream source: presents queued samples in order, advancing only on a real transfer.
  initial begin
    hs.sample_valid = 1'b0;
    hs.sample_in    = '0;
    rd              = 0;
    will_xfer       = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!nRst) begin
        rd        = sq.size();
        will_xfer = 1'b0;
      end else if (will_xfer) begin
        rd = rd + 1;
      end
      hs.sample_valid = (rd < sq.size());
      hs.sample_in    = hs.sample_valid ? W'(sq[rd]) : '0;
      will_xfer       = hs.sample_valid && hs.sample_ready && nRst;
    end
  end

  // Frame recorder: a frame spans from one frame_start cycle to the next.
  initial begin
    open_f   = 1'b0;
    fs_count = 0;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        fq.delete();
        open_f   = 1'b0;
        fs_count = 0;
      end else if (frame_start) begin
        if (open_f) fq.push_back(cur);
        cur.highs = int'(pwm_out);
        cur.len   = 1;
        cur.urun  = underrun;
        cur.rdy   = int'(hs.sample_ready);
        open_f    = 1'b1;
        fs_count  = fs_count + 1;
      end else if (open_f) begin
        cur.highs = cur.highs + int'(pwm_out);
        cur.len   = cur.len + 1;
        cur.urun  = cur.urun | underrun;
        cur.rdy   = cur.rdy + int'(hs.sample_ready);
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fs(input int target);
    int n = 0;
    while (fs_count < target && n < 4000) begin
      step();
      n++;
    end
    chk("wait_frame_start", int'(fs_count >= target), 1);
  endtask

  function automatic int sat_cnt(input int n);
    return (n > (1 << UW) - 1) ? (1 << UW) - 1 : n;
  endfunction

  initial begin
    int L[$];
    int n;
    int last;
    int gap;
    int r1;
    int r2;

    nRst = 1'b0;
    en = 1'b1;
    clr_underrun = 1'b0;
    repeat (3) step();
    chk("rst_ready", int'(hs.sample_ready), 1);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_ucnt", int'(underrun_cnt), 0);
    nRst = 1'b1;
    step();

    // Directed edge duties followed by random ones, streamed back to back, then starve 5 boundaries.
    L = '{5, 3, 12, 0, 15};
    for (int i = 0; i < 6; i++) L.push_back(int'($urandom_range(0, (1 << W) - 1)));
    n = L.size();
    last = L[n-1];
    foreach (L[i]) sq.push_back(L[i]);
    wait_fs(n + 5);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("stream_highs[%0d]", i), fq[i].highs, L[i] * PS);
      chk($sformatf("stream_len[%0d]", i), fq[i].len, FLEN);
      chk($sformatf("stream_urun[%0d]", i), int'(fq[i].urun), 0);
      chk($sformatf("stream_rdy[%0d]", i), fq[i].rdy, (i < n - 1) ? 1 : FLEN);
    end
    for (int i = n; i < n + 4; i++) begin
      chk($sformatf("starve_highs[%0d]", i), fq[i].highs, MUTE ? 0 : last * PS);
      chk($sformatf("starve_len[%0d]", i), fq[i].len, FLEN);
      chk($sformatf("starve_urun[%0d]", i), int'(fq[i].urun), 1);
    end
    chk("ucnt_saturated", int'(underrun_cnt), sat_cnt(5));
    chk("underrun_flag", int'(underrun), 1);

    // Clear coinciding with a starved boundary wins over the increment.
    repeat (47) step();
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    chk("clr_at_boundary_fs", int'(frame_start), 1);
    chk("clr_at_boundary_ucnt", int'(underrun_cnt), 0);

    // Sample offered exactly on a starved boundary: still counted as an underrun.
    repeat (46) step();
    sq.push_back(9);
    step();
    step();
    chk("late_sample_fs", int'(frame_start), 1);
    chk("late_sample_ucnt", int'(underrun_cnt), 1);
    chk("late_sample_underrun", int'(underrun), 1);
    sq.push_back(8);
    sq.push_back(8);
    sq.push_back(8);
    wait_fs(n + 8);
    chk("recover_underrun", int'(underrun), 0);
    chk("recover_ucnt", int'(underrun_cnt), 1);
    wait_fs(n + 9);
    chk("late_sample_highs", fq[n+7].highs, 9 * PS);
    chk("late_sample_len", fq[n+7].len, FLEN);

    // Enable gap mid-frame stretches the frame by the gap length.
    repeat (20) step();
    en = 1'b0;
    gap = 0;
    repeat (10) begin
      step();
      gap = gap + int'(pwm_out);
    end
    en = 1'b1;
    chk("en_gap_pwm_low", gap, 0);
    wait_fs(n + 10);
    chk("en_gap_len", fq[n+8].len, FLEN + 10);
    wait_fs(n + 11);
    chk("after_gap_highs", fq[n+9].highs, 8 * PS);
    chk("after_gap_len", fq[n+9].len, FLEN);

    // Asynchronous reset while the pin is high.
    repeat (10) step();
    chk("pre_reset_pwm", int'(pwm_out), 1);
    @(posedge clk);
    #1;
    nRst = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_fs", int'(frame_start), 0);
    chk("async_rst_ready", int'(hs.sample_ready), 1);
    chk("async_rst_underrun", int'(underrun), 0);
    chk("async_rst_ucnt", int'(underrun_cnt), 0);
    repeat (2) step();
    nRst = 1'b1;

    // Fresh start after reset with two random samples.
    r1 = int'($urandom_range(0, (1 << W) - 1));
    r2 = int'($urandom_range(0, (1 << W) - 1));
    sq.push_back(r1);
    sq.push_back(r2);
    wait_fs(3);
    chk("post_rst_highs0", fq[0].highs, r1 * PS);
    chk("post_rst_highs1", fq[1].highs, r2 * PS);
    chk("post_rst_urun0", int'(fq[0].urun), 0);
    chk("post_rst_underrun", int'(underrun), 1);
    chk("post_rst_ucnt", int'(underrun_cnt), sat_cnt(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
